// File: rtl/rom_load_arbiter.sv
// Program-ROM BRAM arbiter for the sm510 core: host download writes vs CPU fetch,
// CPU reset sequencing and clk_en cadence generation.
module rom_load_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int CLK_DIV    = 4,
  parameter int RESET_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic [ADDR_WIDTH-1:0] cpu_rom_addr,
  output logic [7:0]            cpu_rom_data,
  output logic                  cpu_clk_en,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata,
  output logic                  rom_loaded
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [7:0]    HOLD_LAST = 8'(RESET_HOLD - 1);

  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_e;

  state_e                  state_q, state_d, st;
  logic [7:0]              hold_q, hold_d;
  logic [DW-1:0]           div_q, div_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    loaded_q, loaded_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      div_q    <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      loaded_q <= loaded_d;
    end
  end

  // st is the state seen by this clock: the download level overrides the
  // registered state immediately, so LOAD/HOLD entry takes effect same-clock.
  always_comb begin
    st = state_q;
    if (ioctl_download)       st = LOAD;
    else if (state_q == LOAD) st = HOLD;

    state_d  = st;
    hold_d   = '0;
    div_d    = '0;
    loaded_d = loaded_q;
    case (st)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d  = RUN;
          loaded_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      RUN:     div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      default: ;
    endcase

    wr_d    = ioctl_wr & ioctl_download;
    waddr_d = wr_d ? ioctl_addr : waddr_q;
    wdata_d = wr_d ? ioctl_dout : wdata_q;
    rdata_d = cpu_clk_en ? mem_rdata : rdata_q;
  end

  always_comb begin
    cpu_reset    = (state_q != RUN);
    cpu_clk_en   = (st == RUN) && (div_q == DIV_LAST);
    mem_addr     = (st == RUN) ? cpu_rom_addr : waddr_q;
    mem_we       = wr_q;
    mem_wdata    = wdata_q;
    cpu_rom_data = rdata_q;
    rom_loaded   = loaded_q;
  end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a 1-clock-latency BRAM model.
module tb_rom_load_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [11:0] ioctl_addr, cpu_rom_addr, mem_addr;
  logic [7:0]  ioctl_dout, cpu_rom_data, mem_wdata, mem_rdata;
  logic        cpu_clk_en, cpu_reset, mem_we, rom_loaded;

  logic [7:0]  mem [0:4095];
  logic [7:0]  img [0:3];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  rom_load_arbiter #(.ADDR_WIDTH(12), .CLK_DIV(4), .RESET_HOLD(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_rom_addr(cpu_rom_addr), .cpu_rom_data(cpu_rom_data),
    .cpu_clk_en(cpu_clk_en), .cpu_reset(cpu_reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .rom_loaded(rom_loaded)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_rom_addr = '0; mem_rdata = '0;

    #2;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_clk_en", cpu_clk_en, 0);
    chk("rst_rom_data", cpu_rom_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rom_loaded", rom_loaded, 0);

    // Reset release, no download: 16 hold clocks then RUN
    cyc(); cyc();
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("hold0_cpu_reset", cpu_reset, 1);
      chk("hold0_loaded", rom_loaded, 0);
      cyc();
    end
    for (int r = 0; r < 8; r++) begin
      chk("run0_cpu_reset", cpu_reset, 0);
      chk("run0_clk_en", cpu_clk_en, (r % 4 == 3) ? 1 : 0);
      chk("run0_loaded", rom_loaded, 1);
      cyc();
    end

    // 4-byte download, strobe on the same clock download rises
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 12'h000; ioctl_dout = img[0];
    #1;
    chk("dl_rise_clk_en", cpu_clk_en, 0);
    chk("dl_rise_we", mem_we, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k < 4) begin
        ioctl_addr = 12'(k); ioctl_dout = img[k];
      end else begin
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
      end
      #1;
      chk("dl_we", mem_we, 1);
      chk("dl_addr", mem_addr, k - 1);
      chk("dl_wdata", mem_wdata, img[k-1]);
      chk("dl_cpu_reset", cpu_reset, 1);
    end
    for (int j = 5; j <= 19; j++) begin
      cyc();
      if (j == 5) begin
        chk("dl_we_end", mem_we, 0);
        cpu_rom_addr = 12'h002;
      end
      #1;
      chk("dl_hold_cpu_reset", cpu_reset, 1);
    end
    for (int k = 0; k < 4; k++) chk("dl_mem_image", mem[k], img[k]);

    // First RUN after load: fetch from 0x002
    cyc();
    chk("ld_run_cpu_reset", cpu_reset, 0);
    cyc(); cyc(); cyc();
    chk("ld_first_en", cpu_clk_en, 1);
    chk("ld_data_before_en", cpu_rom_data, 8'hEE);
    cyc();
    chk("ld_data_r4", cpu_rom_data, 8'h33);
    chk("ld_en_r4", cpu_clk_en, 0);
    cyc();
    chk("ld_data_r5", cpu_rom_data, 8'h33);
    cyc();
    chk("ld_data_r6", cpu_rom_data, 8'h33);

    // Download raised at div=2
    ioctl_download = 1'b1;
    #1;
    chk("mid_en_same", cpu_clk_en, 0);
    chk("mid_reset_same", cpu_reset, 0);
    cyc();
    chk("mid_reset_next", cpu_reset, 1);
    chk("mid_en_next", cpu_clk_en, 0);
    chk("mid_data_kept", cpu_rom_data, 8'h33);
    for (int j = 8; j <= 26; j++) begin
      cyc();
      if (j == 8) ioctl_download = 1'b0;
      #1;
      chk("mid_no_en", cpu_clk_en, 0);
      chk("mid_cpu_reset", cpu_reset, (j < 24) ? 1 : 0);
    end
    cyc();
    chk("mid_en_restart", cpu_clk_en, 1);
    chk("mid_data_still", cpu_rom_data, 8'h33);

    // Strobe without download is ignored
    cyc();
    ioctl_wr = 1'b1; ioctl_addr = 12'h005; ioctl_dout = 8'hAA; cpu_rom_addr = 12'h005;
    #1;
    chk("nodl_we0", mem_we, 0);
    cyc();
    ioctl_wr = 1'b0;
    #1;
    chk("nodl_we1", mem_we, 0);
    cyc(); cyc();
    chk("nodl_en", cpu_clk_en, 1);
    cyc();
    chk("nodl_read_old", cpu_rom_data, 8'hEE);
    cyc(); cyc(); cyc();
    ioctl_download = 1'b1;
    #1;
    chk("div3_en_forced", cpu_clk_en, 0);

    // Reset one clock after a LOAD write strobe
    cyc();
    ioctl_wr = 1'b1; ioctl_addr = 12'h007; ioctl_dout = 8'h77;
    #1;
    chk("abort_cpu_reset", cpu_reset, 1);
    cyc();
    ioctl_wr = 1'b0;
    #1;
    chk("abort_we_pre", mem_we, 1);
    chk("abort_addr_pre", mem_addr, 12'h007);
    reset_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_loaded", rom_loaded, 0);
    chk("abort_data", cpu_rom_data, 0);
    ioctl_download = 1'b0;
    cyc();
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("rel_cpu_reset", cpu_reset, 1);
      chk("rel_loaded", rom_loaded, 0);
      chk("rel_clk_en", cpu_clk_en, 0);
      cyc();
    end
    chk("rel_run", cpu_reset, 0);
    chk("rel_loaded_set", rom_loaded, 1);
    chk("abort_mem7", mem[7], 8'hEE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
